// File: rtl/sin_period_meter_if.sv
// Bus between the sine generator / consumer side and sin_period_meter.
//   master : drives ce, co_sin, din, rd_ack; reads the result registers
//   slave  : the meter; reads samples and ack, drives rdy and the results
// Width parameters must match those of the meter the interface connects to.
interface sin_period_meter_if #(
  parameter int DW    = 12,
  parameter int SUM_W = 19,
  parameter int CNT_W = 8
);
  logic             ce;
  logic             co_sin;
  logic [DW-1:0]    din;
  logic             rd_ack;
  logic             rdy;
  logic [DW-1:0]    vmax;
  logic [DW-1:0]    vmin;
  logic [DW-1:0]    vpp;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] nsmp;
  logic             np_err;
  logic             ovr;

  modport master (
    output ce, co_sin, din, rd_ack,
    input  rdy, vmax, vmin, vpp, sum, nsmp, np_err, ovr
  );

  modport slave (
    input  ce, co_sin, din, rd_ack,
    output rdy, vmax, vmin, vpp, sum, nsmp, np_err, ovr
  );
endinterface

// File: rtl/sin_period_meter.sv
// Per-period statistics of the generator's sine output.
// Ports:
//   clk    system clock, everything on posedge
//   rst_n  synchronous active-low reset
//   bus    sin_period_meter_if.slave:
//            in : ce (sample strobe), co_sin (period start), din, rd_ack
//            out: rdy, vmax, vmin, vpp, sum, nsmp, np_err, ovr
//
// State | meaning
// ARM   | waiting for the first period start; no partial period is published
// ACC   | accumulating samples of a period; each period start publishes it
module sin_period_meter #(
  parameter int DW    = 12,
  parameter int SUM_W = 19,
  parameter int CNT_W = 8,
  parameter int NP    = 100
) (
  input logic               clk,
  input logic               rst_n,
  sin_period_meter_if.slave bus
);

  typedef enum logic {ARM, ACC} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    amax_q, amax_d;
  logic [DW-1:0]    amin_q, amin_d;
  logic [SUM_W-1:0] asum_q, asum_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;

  logic [DW-1:0]    vmax_q, vmax_d;
  logic [DW-1:0]    vmin_q, vmin_d;
  logic [DW-1:0]    vpp_q, vpp_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] nsmp_q, nsmp_d;
  logic             np_err_q, np_err_d;
  logic             rdy_q, rdy_d;
  logic             ovr_q, ovr_d;

  logic             publish;

  assign publish = bus.ce && bus.co_sin && (state_q == ACC);

  always_comb begin
    state_d  = state_q;
    amax_d   = amax_q;
    amin_d   = amin_q;
    asum_d   = asum_q;
    acnt_d   = acnt_q;
    vmax_d   = vmax_q;
    vmin_d   = vmin_q;
    vpp_d    = vpp_q;
    sum_d    = sum_q;
    nsmp_d   = nsmp_q;
    np_err_d = np_err_q;
    rdy_d    = rdy_q;
    ovr_d    = ovr_q;

    if (publish) begin
      vmax_d   = amax_q;
      vmin_d   = amin_q;
      vpp_d    = amax_q - amin_q;
      sum_d    = asum_q;
      nsmp_d   = acnt_q;
      np_err_d = (acnt_q != CNT_W'(NP));
    end

    if (bus.ce) begin
      if (bus.co_sin) begin
        // boundary sample opens the new period, never closes the old one
        state_d = ACC;
        amax_d  = bus.din;
        amin_d  = bus.din;
        asum_d  = SUM_W'(bus.din);
        acnt_d  = CNT_W'(1);
      end else if (state_q == ACC) begin
        if (bus.din > amax_q) amax_d = bus.din;
        if (bus.din < amin_q) amin_d = bus.din;
        asum_d = asum_q + SUM_W'(bus.din);
        if (acnt_q != {CNT_W{1'b1}}) acnt_d = acnt_q + CNT_W'(1);
      end
    end

    // ovr can only be set while rdy is set, so it needs no clearing when rdy=0
    if (publish) begin
      rdy_d = 1'b1;
      if (bus.rd_ack)  ovr_d = 1'b0;
      else if (rdy_q)  ovr_d = 1'b1;
    end else if (bus.rd_ack && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARM;
      amax_q   <= '0;
      amin_q   <= '0;
      asum_q   <= '0;
      acnt_q   <= '0;
      vmax_q   <= '0;
      vmin_q   <= '0;
      vpp_q    <= '0;
      sum_q    <= '0;
      nsmp_q   <= '0;
      np_err_q <= 1'b0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      amax_q   <= amax_d;
      amin_q   <= amin_d;
      asum_q   <= asum_d;
      acnt_q   <= acnt_d;
      vmax_q   <= vmax_d;
      vmin_q   <= vmin_d;
      vpp_q    <= vpp_d;
      sum_q    <= sum_d;
      nsmp_q   <= nsmp_d;
      np_err_q <= np_err_d;
      rdy_q    <= rdy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.vmax   = vmax_q;
  assign bus.vmin   = vmin_q;
  assign bus.vpp    = vpp_q;
  assign bus.sum    = sum_q;
  assign bus.nsmp   = nsmp_q;
  assign bus.np_err = np_err_q;
  assign bus.ovr    = ovr_q;

endmodule

// File: tb/tb_sin_period_meter.sv
// Bench for sin_period_meter: a reference model predicts each published
// period, pushes it to a scoreboard queue, and the result is popped and
// compared on the edge that publishes it. rdy/ovr are checked every cycle.
module tb_sin_period_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  sin_period_meter_if #(.DW(12), .SUM_W(19), .CNT_W(8)) bus ();

  sin_period_meter #(.DW(12), .SUM_W(19), .CNT_W(8), .NP(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] vmax;
    logic [11:0] vmin;
    logic [11:0] vpp;
    logic [18:0] sum;
    logic [7:0]  nsmp;
    logic        np_err;
  } res_t;

  res_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_armed = 1'b0;
  logic        m_rdy   = 1'b0;
  logic        m_ovr   = 1'b0;
  logic [11:0] m_max   = '0;
  logic [11:0] m_min   = '0;
  logic [18:0] m_sum   = '0;
  logic [7:0]  m_cnt   = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic co, input logic [11:0] d, input logic ack);
    logic pub;
    res_t e;
    bus.ce     = c;
    bus.co_sin = co;
    bus.din    = d;
    bus.rd_ack = ack;
    pub = rst_n && c && co && m_armed;
    if (!rst_n) begin
      m_armed = 1'b0;
      m_rdy   = 1'b0;
      m_ovr   = 1'b0;
      sb.delete();
    end else begin
      if (pub) begin
        e.vmax   = m_max;
        e.vmin   = m_min;
        e.vpp    = m_max - m_min;
        e.sum    = m_sum;
        e.nsmp   = m_cnt;
        e.np_err = (m_cnt != 8'd100);
        sb.push_back(e);
      end
      if (c && co) begin
        m_armed = 1'b1;
        m_max   = d;
        m_min   = d;
        m_sum   = 19'(d);
        m_cnt   = 8'd1;
      end else if (c && m_armed) begin
        if (d > m_max) m_max = d;
        if (d < m_min) m_min = d;
        m_sum = m_sum + 19'(d);
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      if (pub) begin
        if (ack)        m_ovr = 1'b0;
        else if (m_rdy) m_ovr = 1'b1;
        m_rdy = 1'b1;
      end else if (ack && m_rdy) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (pub) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("vmax",   32'(bus.vmax),   32'(e.vmax));
        chk("vmin",   32'(bus.vmin),   32'(e.vmin));
        chk("vpp",    32'(bus.vpp),    32'(e.vpp));
        chk("sum",    32'(bus.sum),    32'(e.sum));
        chk("nsmp",   32'(bus.nsmp),   32'(e.nsmp));
        chk("np_err", 32'(bus.np_err), 32'(e.np_err));
      end
    end
    chk("rdy", 32'(bus.rdy), 32'(m_rdy));
    chk("ovr", 32'(bus.ovr), 32'(m_ovr));
  endtask

  // Samples start..n-1: value i (or 4095), co_sin on sample 0, gap idle clocks
  // with random din/co_sin after each sample, optional ack on the first one.
  task automatic run(input int start, input int n, input bit co, input bit cst,
                     input int gap, input logic ack_first);
    for (int i = start; i < n; i++) begin
      step(1'b1, co && (i == 0), cst ? 12'hFFF : 12'(i), (i == start) ? ack_first : 1'b0);
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'($urandom_range(0, 1)), 12'($urandom), 1'b0);
    end
  endtask

  task automatic chk_res(input string tag, input int vmax, input int vmin, input int vpp,
                         input int sum, input int nsmp, input int np_err);
    chk({tag, "_vmax"},   32'(bus.vmax),   32'(vmax));
    chk({tag, "_vmin"},   32'(bus.vmin),   32'(vmin));
    chk({tag, "_vpp"},    32'(bus.vpp),    32'(vpp));
    chk({tag, "_sum"},    32'(bus.sum),    32'(sum));
    chk({tag, "_nsmp"},   32'(bus.nsmp),   32'(nsmp));
    chk({tag, "_np_err"}, 32'(bus.np_err), 32'(np_err));
  endtask

  initial begin
    bus.ce = 1'b0;
    bus.co_sin = 1'b0;
    bus.din = '0;
    bus.rd_ack = 1'b0;

    rst_n = 1'b0;
    step(1'b1, 1'b1, 12'd7, 1'b0);
    rst_n = 1'b1;
    chk_res("reset", 0, 0, 0, 0, 0, 0);

    // ramp: partial period, arming period, then a full period published
    run(50, 100, 1'b0, 1'b0, 0, 1'b0);
    run(0, 100, 1'b1, 1'b0, 0, 1'b0);
    chk("arm_rdy", 32'(bus.rdy), 32'd0);
    run(0, 100, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 12'd0, 1'b0);
    chk_res("ramp", 99, 0, 99, 4950, 100, 0);
    chk("ramp_rdy", 32'(bus.rdy), 32'd1);
    run(1, 100, 1'b0, 1'b0, 0, 1'b0);

    // isolated ack with ce low
    step(1'b0, 1'b0, 12'd0, 1'b1);
    chk("ack_rdy", 32'(bus.rdy), 32'd0);
    chk("ack_ovr", 32'(bus.ovr), 32'd0);

    // constant full-scale, two publishes without ack -> overwrite
    run(0, 100, 1'b1, 1'b1, 0, 1'b0);
    run(0, 100, 1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 12'd0, 1'b0);
    chk_res("const", 4095, 4095, 0, 409500, 100, 0);
    chk("ovr_set", 32'(bus.ovr), 32'd1);
    run(1, 100, 1'b0, 1'b0, 2, 1'b0);

    // gapped ramp published together with an ack
    step(1'b1, 1'b1, 12'd0, 1'b1);
    chk_res("gapped", 99, 0, 99, 4950, 100, 0);
    chk("coinc_rdy", 32'(bus.rdy), 32'd1);
    chk("coinc_ovr", 32'(bus.ovr), 32'd0);
    run(1, 60, 1'b0, 1'b0, 0, 1'b0);

    // short period
    step(1'b1, 1'b1, 12'd0, 1'b1);
    chk_res("short", 59, 0, 59, 1770, 60, 1);
    run(1, 50, 1'b0, 1'b0, 0, 1'b0);

    // reset at sample 50, then one arming period and one full period
    rst_n = 1'b0;
    step(1'b1, 1'b0, 12'd50, 1'b0);
    rst_n = 1'b1;
    chk_res("mid_rst", 0, 0, 0, 0, 0, 0);
    run(51, 100, 1'b0, 1'b0, 0, 1'b0);
    run(0, 100, 1'b1, 1'b0, 0, 1'b0);
    chk("rst_arm_rdy", 32'(bus.rdy), 32'd0);
    run(0, 100, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 12'd0, 1'b0);
    chk_res("post_rst", 99, 0, 99, 4950, 100, 0);
    chk("post_rst_rdy", 32'(bus.rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
